pe_kl_config_bank: RTL and testbench
====================================

Name: pe_kl_config_bank

Overview:
- Multi-entry key/lock configuration bank for a processing element (PE) in the convolution array.
- Successor to the single-lock PE config block. Stores up to DEPTH lock words and one key, loaded over a valid/ready config stream.
- Flags a registered match when the key equals any stored lock. Supports an optional don't-care mask.
- Sits between the array config distributor and the PE calculation control.

Parameters:
- BUS_WIDTH, 16, width of lock, key and mask words.
- DEPTH, 4, number of lock slots (≥2, power of two not required).
- IDX_W, $clog2(DEPTH), width of slot index; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  bank can accept a config word
- cfg_type  in  2  00 LOCK, 01 KEY, 10 CLEAR, 11 MASK
- cfg_data  in  BUS_WIDTH  config payload (ignored for CLEAR)
- kl_valid  out  1  registered: key matches a stored lock
- kl_idx  out  IDX_W  lowest matching slot index (0 when kl_valid=0)
- lock_cnt  out  IDX_W+1  number of stored locks, 0..DEPTH
- state  out  2  00 IDLE, 01 LOAD, 10 ARMED, 11 CLEAR
- cfg_err  out  1  one-cycle pulse on a rejected config word

Behaviour:
- Reset (rst=0, async): state=IDLE, lock_cnt=0, all slots=0, key=0, mask=0, kl_valid=0, kl_idx=0, cfg_err=0, cfg_ready=1.
- Handshake: a word is accepted at a rising edge with cfg_valid&cfg_ready. While cfg_ready=0, cfg_data/cfg_type are don't-care and no state changes.
- cfg_ready=0 only in CLEAR; otherwise 1.
- LOCK, any state except CLEAR:
  - If lock_cnt<DEPTH: slot[lock_cnt]<=cfg_data, lock_cnt++, IDLE→LOAD; state is otherwise unchanged.
  - If lock_cnt==DEPTH: word dropped, cfg_err pulses next cycle, no other change.
- KEY:
  - In IDLE: rejected with cfg_err, key unchanged.
  - In LOAD or ARMED: key<=cfg_data, state→ARMED.
- CLEAR, any accepting state: state→CLEAR, internal wipe pointer=0, kl_valid<=0.
  - In CLEAR, one slot is zeroed per cycle (pointer 0..DEPTH-1).
  - After the slot DEPTH-1 write: lock_cnt=0, key=0, mask=0, state→IDLE, cfg_ready=1 next cycle.
  - CLEAR occupies exactly DEPTH cycles with cfg_ready=0.
- MASK: behaviour per Optional Feature.
- Compare, registered:
  - Each cycle in ARMED: hit[i] = (i<lock_cnt) & (((key^slot[i]) & ~mask)==0).
  - kl_valid<=|hit; kl_idx<=lowest i with hit[i], else 0.
  - Outside ARMED: kl_valid<=0, kl_idx<=0.
- Latency: a KEY or LOCK accepted at edge N updates storage at N; kl_valid/kl_idx reflect it after edge N+1.
- Simultaneous events:
  - Only one config word per cycle exists, so there is no intra-port conflict.
  - A LOCK in ARMED appends and the compare includes it one cycle later. kl_valid may rise without a new key.
- Async reset during CLEAR aborts the wipe and applies reset values immediately.
- Unsigned bitwise compare only; no arithmetic. lock_cnt saturates at DEPTH by rejection, never wraps.

Optional Feature:
- Macro KL_MASK_EN.
- Defined: MASK is accepted in LOAD/ARMED/IDLE and loads mask<=cfg_data. Set mask bits are don't-care in the compare.
- Not defined: mask is tied to 0 and the compare is exact. A MASK word is accepted (handshake completes) but ignored, and cfg_err pulses.

Test Plan:
- Reset, then KEY 0x1234 in IDLE → cfg_err pulse, state stays IDLE, kl_valid=0.
- LOCK 0xAAAA, LOCK 0x1234, then KEY 0x1234 → state ARMED, kl_valid=1, kl_idx=1 one edge after key accept, lock_cnt=2.
- Fill DEPTH=4 locks, send a 5th LOCK 0xBEEF → cfg_err pulse, lock_cnt stays 4, slots unchanged; re-send KEY 0xBEEF → kl_valid=0.
- ARMED with key 0x00FF and no match, then LOCK 0x00FF → kl_valid rises 1 cycle after the lock is accepted, kl_idx=new slot.
- CLEAR while ARMED → cfg_ready=0 for exactly 4 cycles, kl_valid=0 next edge, then state IDLE, lock_cnt=0; LOCK presented during CLEAR is held until ready.
- KL_MASK_EN defined: LOCK 0x12F0, MASK 0x00FF, KEY 0x1234 → kl_valid=1, kl_idx=0. Undefined: same sequence → cfg_err pulse on MASK, kl_valid=0.

Source files
------------

// File: rtl/pe_kl_config_bank_if.sv
// Config stream and match/status bus between the array config distributor
// and one PE key/lock bank. master = distributor side, slave = bank side.
// Both ends must agree on BUS_WIDTH and DEPTH.
interface pe_kl_config_bank_if #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_type;
  logic [BUS_WIDTH-1:0] cfg_data;
  logic                 kl_valid;
  logic [IDX_W-1:0]     kl_idx;
  logic [IDX_W:0]       lock_cnt;
  logic [1:0]           state;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_type, cfg_data,
    input  cfg_ready, kl_valid, kl_idx, lock_cnt, state, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_type, cfg_data,
    output cfg_ready, kl_valid, kl_idx, lock_cnt, state, cfg_err
  );
endinterface

// File: rtl/pe_kl_config_bank.sv
// Key/lock bank: stores up to DEPTH lock words plus one key, flags when the key matches a lock.
// Latency: config word updates storage at its accept edge; kl_valid/kl_idx follow one edge later.
// Backpressure: cfg_ready drops only while CLEAR wipes the slots (exactly DEPTH cycles).
// Optional don't-care mask is enabled by defining KL_MASK_EN.
module pe_kl_config_bank #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  pe_kl_config_bank_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  localparam logic [1:0] CFG_LOCK  = 2'b00;
  localparam logic [1:0] CFG_KEY   = 2'b01;
  localparam logic [1:0] CFG_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_ARMED = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_slot [DEPTH];
  logic [BUS_WIDTH-1:0] r_key;
  logic [CNT_W-1:0]     r_lock_cnt;
  logic [IDX_W-1:0]     r_wipe_ptr;
  logic                 r_kl_valid;
  logic [IDX_W-1:0]     r_kl_idx;
  logic                 r_cfg_err;

  logic [BUS_WIDTH-1:0] w_mask;
  logic                 w_accept;
  logic [DEPTH-1:0]     w_hit;
  logic [IDX_W-1:0]     w_hit_idx;

  // CLEAR is the only state that refuses words, so accept is just valid outside it
  assign w_accept = bus.cfg_valid && (r_state != ST_CLEAR);

  // Masked compare against each occupied slot; descending scan leaves the lowest hit index
  always_comb begin
    w_hit     = '0;
    w_hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_hit[i] = (CNT_W'(i) < r_lock_cnt) && (((r_key ^ r_slot[i]) & ~w_mask) == '0);
      if (w_hit[i]) begin
        w_hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef KL_MASK_EN
  logic [BUS_WIDTH-1:0] r_mask;

  // Mask register: loaded by MASK words, wiped together with the key at the end of CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
    end else if (w_accept && bus.cfg_type == 2'b11) begin
      r_mask <= bus.cfg_data;
    end else if (r_state == ST_CLEAR && r_wipe_ptr == LAST_PTR) begin
      r_mask <= '0;
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif

  // Config FSM, slot storage, wipe sequencing and the registered match result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
      r_wipe_ptr <= '0;
      r_key      <= '0;
      r_kl_valid <= 1'b0;
      r_kl_idx   <= '0;
      r_cfg_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_cfg_err <= 1'b0;

      // w_hit_idx is already 0 when nothing hits
      if (r_state == ST_ARMED) begin
        r_kl_valid <= |w_hit;
        r_kl_idx   <= w_hit_idx;
      end else begin
        r_kl_valid <= 1'b0;
        r_kl_idx   <= '0;
      end

      if (r_state == ST_CLEAR) begin
        r_slot[r_wipe_ptr] <= '0;
        r_wipe_ptr         <= r_wipe_ptr + IDX_W'(1);
        if (r_wipe_ptr == LAST_PTR) begin
          r_wipe_ptr <= '0;
          r_lock_cnt <= '0;
          r_key      <= '0;
          r_state    <= ST_IDLE;
        end
      end else if (w_accept) begin
        case (bus.cfg_type)
          CFG_LOCK: begin
            // A full bank rejects rather than wraps
            if (r_lock_cnt < CNT_W'(DEPTH)) begin
              r_slot[r_lock_cnt[IDX_W-1:0]] <= bus.cfg_data;
              r_lock_cnt                    <= r_lock_cnt + CNT_W'(1);
              if (r_state == ST_IDLE) begin
                r_state <= ST_LOAD;
              end
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
          CFG_KEY: begin
            if (r_state == ST_IDLE) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_key   <= bus.cfg_data;
              r_state <= ST_ARMED;
            end
          end
          CFG_CLEAR: begin
            r_state    <= ST_CLEAR;
            r_wipe_ptr <= '0;
            r_kl_valid <= 1'b0;
            r_kl_idx   <= '0;
          end
          default: begin
            // MASK: handled by the mask register when present, otherwise refused
`ifndef KL_MASK_EN
            r_cfg_err <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

  assign bus.cfg_ready = (r_state != ST_CLEAR);
  assign bus.kl_valid  = r_kl_valid;
  assign bus.kl_idx    = r_kl_idx;
  assign bus.lock_cnt  = r_lock_cnt;
  assign bus.state     = r_state;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_pe_kl_config_bank.sv
// Bench for pe_kl_config_bank: directed vector table, hand-written CLEAR and
// async-reset sequences, then random config traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pe_kl_config_bank;
  localparam int BW    = 16;
  localparam int DEPTH = 4;

  localparam logic [1:0] T_LOCK  = 2'b00;
  localparam logic [1:0] T_KEY   = 2'b01;
  localparam logic [1:0] T_CLEAR = 2'b10;
  localparam logic [1:0] T_MASK  = 2'b11;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_ARMED = 2;
  localparam int S_CLEAR = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pe_kl_config_bank_if #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) bus ();

  pe_kl_config_bank #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: locks kept as a queue, CLEAR as a countdown.
  logic [BW-1:0] m_locks[$];
  logic [BW-1:0] m_key;
  logic [BW-1:0] m_mask;
  int            m_state;
  int            m_clear_left;
  logic          m_klv;
  int            m_idx;
  logic          m_err;

  task automatic model_reset();
    m_locks.delete();
    m_key = '0; m_mask = '0; m_state = S_IDLE; m_clear_left = 0;
    m_klv = 1'b0; m_idx = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] t, input logic [BW-1:0] d);
    logic nv;
    int   nidx;
    nv = 1'b0; nidx = 0;
    if (m_state == S_ARMED)
      for (int i = 0; i < m_locks.size(); i++)
        if (!nv && (((m_key ^ m_locks[i]) & ~m_mask) == '0)) begin
          nv = 1'b1; nidx = i;
        end
    m_err = 1'b0;
    if (m_state == S_CLEAR) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_locks.delete(); m_key = '0; m_mask = '0; m_state = S_IDLE;
      end
    end else if (v) begin
      case (t)
        T_LOCK: begin
          if (m_locks.size() < DEPTH) begin
            m_locks.push_back(d);
            if (m_state == S_IDLE) m_state = S_LOAD;
          end else m_err = 1'b1;
        end
        T_KEY: begin
          if (m_state == S_IDLE) m_err = 1'b1;
          else begin m_key = d; m_state = S_ARMED; end
        end
        T_CLEAR: begin
          m_state = S_CLEAR; m_clear_left = DEPTH; nv = 1'b0; nidx = 0;
        end
        default: begin
`ifdef KL_MASK_EN
          m_mask = d;
`else
          m_err = 1'b1;
`endif
        end
      endcase
    end
    m_klv = nv; m_idx = nidx;
  endtask

  // One clock: drive at negedge, model follows the edge, caller samples at the next negedge.
  task automatic drive(input logic v, input logic [1:0] t, input logic [BW-1:0] d);
    bus.cfg_valid = v; bus.cfg_type = t; bus.cfg_data = d;
    @(posedge clk);
    model_step(v, t, d);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"},    32'(bus.state),     32'(m_state));
    check({tag, "_lock_cnt"}, 32'(bus.lock_cnt),  32'(m_locks.size()));
    check({tag, "_ready"},    32'(bus.cfg_ready), 32'(m_state != S_CLEAR));
    check({tag, "_err"},      32'(bus.cfg_err),   32'(m_err));
    check({tag, "_kl_valid"}, 32'(bus.kl_valid),  32'(m_klv));
    check({tag, "_kl_idx"},   32'(bus.kl_idx),    32'(m_idx));
  endtask

  task automatic do_reset();
    bus.cfg_valid = 1'b0; bus.cfg_type = T_LOCK; bus.cfg_data = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic          v;
    logic [1:0]    t;
    logic [BW-1:0] d;
    int            st;
    int            cnt;
    logic          err;
    logic          klv;
    int            idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] t, input logic [BW-1:0] d,
                     input int st, input int cnt, input logic err, input logic klv, input int idx);
    vec_t r;
    r.v = v; r.t = t; r.d = d; r.st = st; r.cnt = cnt; r.err = err; r.klv = klv; r.idx = idx;
    vecs.push_back(r);
  endtask

  task automatic add_idle(input int n, input int st, input int cnt);
    for (int i = 0; i < n; i++) add(1'b0, T_LOCK, 16'h0, st, cnt, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic          rv;
    logic [1:0]    rt;
    logic [BW-1:0] rd;
    int            sel;

    // ---------------- reset values ----------------
    do_reset();
    check("rst_state",    32'(bus.state),     0);
    check("rst_lock_cnt", 32'(bus.lock_cnt),  0);
    check("rst_ready",    32'(bus.cfg_ready), 1);
    check("rst_err",      32'(bus.cfg_err),   0);
    check("rst_kl_valid", 32'(bus.kl_valid),  0);
    check("rst_kl_idx",   32'(bus.kl_idx),    0);

    // ---------------- directed vector table ----------------
    // Expected values are sampled one negedge after the edge that takes the row.
    add(1'b1, T_KEY,  16'h1234, S_IDLE,  0, 1'b1, 1'b0, 0);  // KEY in IDLE refused
    add_idle(1, S_IDLE, 0);
    add(1'b1, T_LOCK, 16'hAAAA, S_LOAD,  1, 1'b0, 1'b0, 0);
    add(1'b1, T_LOCK, 16'h1234, S_LOAD,  2, 1'b0, 1'b0, 0);
    add(1'b1, T_KEY,  16'h1234, S_ARMED, 2, 1'b0, 1'b0, 0);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 2, 1'b0, 1'b1, 1);  // match on slot 1
    add(1'b1, T_LOCK, 16'h5555, S_ARMED, 3, 1'b0, 1'b1, 1);
    add(1'b1, T_LOCK, 16'h6666, S_ARMED, 4, 1'b0, 1'b1, 1);
    add(1'b1, T_LOCK, 16'hBEEF, S_ARMED, 4, 1'b1, 1'b1, 1);  // bank full
    add(1'b1, T_KEY,  16'hBEEF, S_ARMED, 4, 1'b0, 1'b1, 1);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 4, 1'b0, 1'b0, 0);  // BEEF was never stored
    add(1'b1, T_CLEAR,16'h0000, S_CLEAR, 4, 1'b0, 1'b0, 0);
    add_idle(3, S_CLEAR, 4);
    add_idle(1, S_IDLE, 0);
    add(1'b1, T_LOCK, 16'h1111, S_LOAD,  1, 1'b0, 1'b0, 0);
    add(1'b1, T_KEY,  16'h00FF, S_ARMED, 1, 1'b0, 1'b0, 0);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 1, 1'b0, 1'b0, 0);  // armed, no match
    add(1'b1, T_LOCK, 16'h00FF, S_ARMED, 2, 1'b0, 1'b0, 0);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 2, 1'b0, 1'b1, 1);  // new lock matches
    add(1'b1, T_CLEAR,16'h0000, S_CLEAR, 2, 1'b0, 1'b0, 0);
    add_idle(3, S_CLEAR, 2);
    add_idle(1, S_IDLE, 0);
    add(1'b1, T_LOCK, 16'h12F0, S_LOAD,  1, 1'b0, 1'b0, 0);
`ifdef KL_MASK_EN
    add(1'b1, T_MASK, 16'h00FF, S_LOAD,  1, 1'b0, 1'b0, 0);
    add(1'b1, T_KEY,  16'h1234, S_ARMED, 1, 1'b0, 1'b0, 0);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 1, 1'b0, 1'b1, 0);
`else
    add(1'b1, T_MASK, 16'h00FF, S_LOAD,  1, 1'b1, 1'b0, 0);
    add(1'b1, T_KEY,  16'h1234, S_ARMED, 1, 1'b0, 1'b0, 0);
    add(1'b0, T_LOCK, 16'h0000, S_ARMED, 1, 1'b0, 1'b0, 0);
`endif
    add(1'b1, T_CLEAR,16'h0000, S_CLEAR, 1, 1'b0, 1'b0, 0);
    add_idle(3, S_CLEAR, 1);
    add_idle(1, S_IDLE, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].t, vecs[k].d);
      check($sformatf("vec%0d_state", k),    32'(bus.state),     32'(vecs[k].st));
      check($sformatf("vec%0d_lock_cnt", k), 32'(bus.lock_cnt),  32'(vecs[k].cnt));
      check($sformatf("vec%0d_ready", k),    32'(bus.cfg_ready), 32'(vecs[k].st != S_CLEAR));
      check($sformatf("vec%0d_err", k),      32'(bus.cfg_err),   32'(vecs[k].err));
      check($sformatf("vec%0d_kl_valid", k), 32'(bus.kl_valid),  32'(vecs[k].klv));
      check($sformatf("vec%0d_kl_idx", k),   32'(bus.kl_idx),    32'(vecs[k].idx));
    end

    // ---------------- LOCK held while CLEAR wipes ----------------
    do_reset();
    drive(1'b1, T_LOCK, 16'h0A0A);
    drive(1'b1, T_KEY,  16'h0A0A);
    drive(1'b0, T_LOCK, 16'h0000);
    check("hold_armed_hit", 32'(bus.kl_valid), 1);
    drive(1'b1, T_CLEAR, 16'h0000);
    check("hold_clear_state", 32'(bus.state),    S_CLEAR);
    check("hold_clear_klv",   32'(bus.kl_valid), 0);
    bus.cfg_valid = 1'b1; bus.cfg_type = T_LOCK; bus.cfg_data = 16'h7777;
    n = 0;
    for (int g = 0; g < 20 && !bus.cfg_ready; g++) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_busy_cycles", 32'(n), 4);
    check("hold_wiped_cnt",   32'(bus.lock_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    check("hold_lock_state", 32'(bus.state),    S_LOAD);
    check("hold_lock_cnt",   32'(bus.lock_cnt), 1);

    // ---------------- async reset aborts a wipe ----------------
    drive(1'b1, T_CLEAR, 16'h0000);
    drive(1'b0, T_LOCK,  16'h0000);
    check("arst_pre_state", 32'(bus.state), S_CLEAR);
    #2 rst = 1'b0;
    #1;
    check("arst_state", 32'(bus.state),     0);
    check("arst_ready", 32'(bus.cfg_ready), 1);
    check("arst_cnt",   32'(bus.lock_cnt),  0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // ---------------- random traffic vs model ----------------
    for (int c = 0; c < 800; c++) begin
      rv  = ($urandom_range(0, 99) < 75);
      sel = $urandom_range(0, 15);
      if (sel < 7)       rt = T_LOCK;
      else if (sel < 12) rt = T_KEY;
      else if (sel < 13) rt = T_CLEAR;
      else               rt = T_MASK;
      case ($urandom_range(0, 4))
        0:       rd = 16'h1234;
        1:       rd = 16'h00FF;
        2:       rd = 16'h12F0;
        3:       rd = 16'hAAAA;
        default: rd = 16'($urandom);
      endcase
      drive(rv, rt, rd);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
